// File: rtl/wb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// wb_mem_slave_if
//   Wishbone classic-cycle bus bundle between a master (cache/LSU) and the
//   wb_mem_slave memory responder. Signal names keep the slave-side view:
//   the _i signals are driven by the master and the _o signals by the slave.
//
//   Signals:
//     wb_cyc_i  bus cycle in progress
//     wb_stb_i  strobe; request valid while wb_cyc_i is also high
//     wb_we_i   1 = write, 0 = read
//     wb_sel_i  byte lane enables, bit n covers data[8n+7:8n]
//     wb_adr_i  byte address; bits [1:0] are ignored by the slave
//     wb_dat_i  write data
//     wb_dat_o  read data, valid only while wb_ack_o is high
//     wb_ack_o  transfer done, one-cycle pulse
//     wb_err_o  transfer failed, one-cycle pulse
//
//   Modports: slave (memory side), master (requester side).
// ---------------------------------------------------------------------------
interface wb_mem_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_mem_slave.sv
// ---------------------------------------------------------------------------
// wb_mem_slave
//   Wishbone classic-cycle slave backed by an on-chip array of 32-bit words.
//   Serves single-word reads and byte-enabled writes with a programmable
//   number of wait states between request capture and acknowledge.
//
//   Ports:
//     clk    rising-edge clock for all logic
//     rst_i  synchronous, active-high reset (memory contents are kept)
//     bus    wb_mem_slave_if.slave bundle (cyc/stb/we/sel/adr/dat in,
//            dat/ack/err out)
//
//   Parameters:
//     DEPTH        number of words, power of two, >= 2
//     BASE_ADDR    byte address of word 0, aligned to DEPTH*4
//     WAIT_STATES  0..15 extra cycles between capture and response
//
//   Timing: a request captured at edge T is answered in the cycle that
//   follows edge T+WAIT_STATES, so transfers are spaced 2+WAIT_STATES cycles
//   apart when strobe is held high.
//
//   Optional feature macro: WB_MEM_ERR_EN
//     defined   - out-of-range accesses finish with wb_err_o instead of
//                 wb_ack_o, with no write and zero read data.
//     undefined - wb_err_o stays 0 and out-of-range addresses alias into
//                 the array modulo DEPTH.
// ---------------------------------------------------------------------------
module wb_mem_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst_i,
  wb_mem_slave_if.slave      bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [32:0] SPAN    = 33'(DEPTH) * 33'd4;
  // Counter preload; the WAIT state is skipped entirely when WAIT_STATES is 0.
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [3:0]     cnt_r;
  logic [3:0]     cnt_nx_s;

  // Latched request
  logic           we_r;
  logic [3:0]     sel_r;
  logic [31:0]    adr_r;
  logic [31:0]    wdat_r;

  // Registered bus outputs
  logic           ack_r;
  logic           err_r;
  logic [31:0]    rdat_r;

  logic [31:0]    mem_r [DEPTH];

  logic           req_s;
  logic           capture_s;
  logic           commit_s;
  logic [31:0]    src_adr_s;
  logic           src_we_s;
  logic [31:0]    offset_s;
  logic [AW-1:0]  idx_s;
  logic           hit_s;
  logic           resp_nx_s;
  logic           ack_nx_s;
  logic           err_nx_s;
  logic [31:0]    rdat_nx_s;

  assign req_s     = bus.wb_cyc_i & bus.wb_stb_i;
  assign capture_s = (state_r == ST_IDLE) & req_s;

  // In IDLE the live bus request is decoded so that a zero-wait response can
  // fetch read data on the capture edge; afterwards the latched copy is used.
  assign src_adr_s = (state_r == ST_IDLE) ? bus.wb_adr_i : adr_r;
  assign src_we_s  = (state_r == ST_IDLE) ? bus.wb_we_i  : we_r;
  assign offset_s  = src_adr_s - BASE_ADDR;
  assign idx_s     = offset_s[AW+1:2];

`ifdef WB_MEM_ERR_EN
  assign hit_s = ({1'b0, offset_s} < SPAN);
`else
  logic unused_s;
  // Offset bits above the array index only matter for range checking.
  assign unused_s = ^{offset_s[31:AW+2], offset_s[1:0]};
  assign hit_s    = 1'b1;
`endif

  // In RESP the decode is driven from the latched address, so idx_s and
  // hit_s describe the request being acknowledged.
  assign commit_s = (state_r == ST_RESP) & we_r & hit_s;

  // Next-state and wait-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (WAIT_STATES == 0) begin
            state_nx_s = ST_RESP;
          end else begin
            state_nx_s = ST_WAIT;
            cnt_nx_s   = WS_LOAD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Dropping cyc abandons the transfer before anything is committed.
        if (!bus.wb_cyc_i) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_nx_s = ST_RESP;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Next values of the registered response outputs, valid for the RESP cycle.
  always_comb begin
    resp_nx_s = (state_nx_s == ST_RESP);
    ack_nx_s  = 1'b0;
    err_nx_s  = 1'b0;
    rdat_nx_s = 32'h0000_0000;
    if (resp_nx_s) begin
      ack_nx_s = hit_s;
      err_nx_s = ~hit_s;
      if (hit_s && !src_we_s) begin
        rdat_nx_s = mem_r[idx_s];
      end else begin
        rdat_nx_s = 32'h0000_0000;
      end
    end else begin
      ack_nx_s  = 1'b0;
      err_nx_s  = 1'b0;
      rdat_nx_s = 32'h0000_0000;
    end
  end

  // State, counter and response output registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdat_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      ack_r   <= ack_nx_s;
      err_r   <= err_nx_s;
      rdat_r  <= rdat_nx_s;
    end
  end

  // Request capture; the latched copy is held until the next capture.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      we_r   <= 1'b0;
      sel_r  <= 4'h0;
      adr_r  <= 32'h0000_0000;
      wdat_r <= 32'h0000_0000;
    end else if (capture_s) begin
      we_r   <= bus.wb_we_i;
      sel_r  <= bus.wb_sel_i;
      adr_r  <= bus.wb_adr_i;
      wdat_r <= bus.wb_dat_i;
    end
  end

  // Byte-lane write commit on the edge that ends RESP; a reset on that edge
  // discards the write.
  always_ff @(posedge clk) begin
    if (commit_s && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_r[b]) begin
          mem_r[idx_s][8*b +: 8] <= wdat_r[8*b +: 8];
        end
      end
    end
  end

  assign bus.wb_ack_o = ack_r;
  assign bus.wb_err_o = err_r;
  assign bus.wb_dat_o = rdat_r;

endmodule

// File: tb/tb_wb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_mem_slave
//   Self-checking bench for wb_mem_slave (DEPTH=1024, BASE 0, 1 wait state).
//   Directed vector table, hand-written multi-cycle sequences (back-to-back,
//   abort, reset mid-transfer) and a randomized phase against a word-array
//   reference model.
// ---------------------------------------------------------------------------
module tb_wb_mem_slave;

  localparam int unsigned DEPTH = 1024;
  localparam int          WS    = 1;
`ifdef WB_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_i;
  int   tests;
  int   fails;

  wb_mem_slave_if bus ();

  wb_mem_slave #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (WS)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 32'h0;
    bus.wb_dat_i = 32'h0;
  endtask

  // One complete transfer; lat counts negedges after the request is driven.
  task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, output logic ack, output logic err,
                      output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    ack = 1'b0; err = 1'b0; rd = 32'h0; lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o) begin
        ack = bus.wb_ack_o;
        err = bus.wb_err_o;
        rd  = bus.wb_dat_o;
        lat = n;
        break;
      end
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("single_pulse", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
    check("dat_idle_zero", bus.wb_dat_o, 32'h0);
  endtask

  logic        a, e;
  logic [31:0] rd;
  int          lat;

  initial begin
    tests = 0;
    fails = 0;
    bus_idle();

    // Reset then idle
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle_ackerr", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
      check("reset_idle_dat", bus.wb_dat_o, 32'h0);
    end

    // Directed vector table
    vecs.push_back('{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 4'h5, 32'h10,   32'h11223344, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDE22BE44});
    vecs.push_back('{1'b1, 4'h0, 32'h10,   32'hFFFFFFFF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDE22BE44});
    vecs.push_back('{1'b1, 4'hF, 32'h0,    32'h1,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h4,    32'h2,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h8,    32'h3,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'hC,    32'h4,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h20,   32'h0,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h1000, 32'h0,        !ERR_EN, ERR_EN, ERR_EN ? 32'h0 : 32'h1});
    vecs.push_back('{1'b1, 4'hF, 32'h1004, 32'h55,       !ERR_EN, ERR_EN, 32'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h4,    32'h0,        1'b1, 1'b0, ERR_EN ? 32'h2 : 32'h55});
    vecs.push_back('{1'b1, 4'hF, 32'h4,    32'h2,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'hA, 32'h13,   32'h0,        1'b1, 1'b0, 32'hDE22BE44});

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, a, e, rd, lat);
      check($sformatf("vec%0d_ack", i), {31'h0, a}, {31'h0, vecs[i].exp_ack});
      check($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_lat", i), lat, WS + 2);
      if (!vecs[i].we) begin
        check($sformatf("vec%0d_rdat", i), rd, vecs[i].exp_dat);
      end
    end

    // Back-to-back reads with strobe held high
    begin
      int got;
      int prev;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_sel_i = 4'hF;
      bus.wb_adr_i = 32'h0;
      got  = 0;
      prev = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
        @(negedge clk);
        if (bus.wb_ack_o) begin
          check("b2b_data", bus.wb_dat_o, 32'(got + 1));
          if (got > 0) check("b2b_spacing", c - prev, WS + 2);
          prev = c;
          got++;
          if (got < 4) bus.wb_adr_i = 32'(got * 4);
          else bus_idle();
        end
      end
      bus_idle();
      check("b2b_count", got, 4);
    end

    // Abort: cyc dropped during WAIT on a write
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = 32'h20; bus.wb_dat_i = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_wait_noack", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_noack", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
    end
    xfer(1'b0, 4'hF, 32'h20, 32'h0, a, e, rd, lat);
    check("abort_read_ack", {31'h0, a}, 32'h1);
    check("abort_read_data", rd, 32'h0);

    // Reset pulsed during WAIT on the same write
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = 32'h20; bus.wb_dat_i = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_noack", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
    end
    xfer(1'b0, 4'hF, 32'h20, 32'h0, a, e, rd, lat);
    check("rst_read_ack", {31'h0, a}, 32'h1);
    check("rst_read_data", rd, 32'h0);

    // Randomized phase: preload 16 words, then mixed traffic vs model
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      xfer(1'b1, 4'hF, 32'(i * 4), model[i], a, e, rd, lat);
      check("preload_ack", {31'h0, a}, 32'h1);
    end
    for (int t = 0; t < 200; t++) begin
      logic        rwe;
      logic [3:0]  rsel;
      int          ridx;
      logic [31:0] radr;
      logic [31:0] rdat;
      rwe  = 1'($urandom_range(0, 1));
      rsel = 4'($urandom_range(0, 15));
      ridx = $urandom_range(0, 15);
      radr = 32'(ridx * 4 + $urandom_range(0, 3));
      rdat = $urandom;
      xfer(rwe, rsel, radr, rdat, a, e, rd, lat);
      check("rand_ack", {30'h0, a, e}, 32'h2);
      check("rand_lat", lat, WS + 2);
      if (rwe) begin
        for (int b = 0; b < 4; b++) begin
          if (rsel[b]) model[ridx][8*b +: 8] = rdat[8*b +: 8];
        end
      end else begin
        check("rand_rdat", rd, model[ridx]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
